// File: rtl/backbone_j_collect_fix.sv
// Collects the raw backbone word plus J-1 streamed backbone_J quotients into one
// J-entry vector with its unsigned sum. The output is double-buffered behind a shadow copy.
module backbone_j_collect_fix #(
  parameter  int J       = 14,
  parameter  int TIMEOUT = 64,
  localparam int SUM_W   = 32 + $clog2(J),
  localparam int J_WIDTH = $clog2(J) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        backbone,
  input  logic               backbone_tvalid,
  input  logic [31:0]        backbone_J,
  input  logic               backbone_J_tvalid,
  output logic [J*32-1:0]    backbone_vec,
  output logic               backbone_vec_tvalid,
  output logic [SUM_W-1:0]   backbone_sum,
  output logic               busy,
  output logic               frame_err
);

  localparam int IDX_W = $clog2(J);
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  localparam logic [J_WIDTH-1:0] LAST_IDX  = J_WIDTH'(J - 1);
  localparam logic [WD_W-1:0]    TIMEOUT_C = WD_W'(TIMEOUT);

  logic [1:0]            state_q, state_d;
  logic [J_WIDTH-1:0]    idx_q, idx_d;
  logic [WD_W-1:0]       wd_q, wd_d, wd_inc;
  logic [SUM_W-1:0]      acc_q, acc_d;
  logic [J-1:0][31:0]    shadow_q, shadow_d;
  logic [J-1:0][31:0]    vec_q, vec_d;
  logic [SUM_W-1:0]      sum_q, sum_d;
  logic                  vld_q, vld_d;
  logic                  err_q, err_d;

  assign wd_inc = wd_q + WD_W'(1);

  // NOTE: every variable gets a default at the top so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    wd_d     = wd_q;
    acc_d    = acc_q;
    shadow_d = shadow_q;
    vec_d    = vec_q;
    sum_d    = sum_q;
    vld_d    = 1'b0;
    err_d    = 1'b0;

    // DONE publishes the pre-update shadow, then behaves like IDLE for new input.
    if (state_q == S_DONE) begin
      vec_d   = shadow_q;
      sum_d   = acc_q;
      vld_d   = 1'b1;
      state_d = S_IDLE;
    end

    if (state_q == S_COLLECT) begin
      if (backbone_tvalid) begin
        shadow_d[0] = backbone;
        acc_d       = SUM_W'(backbone);
        idx_d       = J_WIDTH'(1);
        wd_d        = '0;
        err_d       = 1'b1;
      end else if (backbone_J_tvalid) begin
        shadow_d[idx_q[IDX_W-1:0]] = backbone_J;
        acc_d = acc_q + SUM_W'(backbone_J);
        wd_d  = '0;
        if (idx_q == LAST_IDX) state_d = S_DONE;
        else                   idx_d   = idx_q + J_WIDTH'(1);
      end else if (wd_inc == TIMEOUT_C) begin
        state_d = S_IDLE;
        wd_d    = '0;
        err_d   = 1'b1;
      end else begin
        wd_d = wd_inc;
      end
    end else begin
      if (backbone_tvalid) begin
        shadow_d[0] = backbone;
        acc_d       = SUM_W'(backbone);
        idx_d       = J_WIDTH'(1);
        wd_d        = '0;
        state_d     = S_COLLECT;
      end
      if (backbone_J_tvalid) err_d = 1'b1;
    end
  end

  // NOTE: the shadow and output arrays are reset too, because a zero vector after reset is observable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      wd_q     <= '0;
      acc_q    <= '0;
      shadow_q <= '0;
      vec_q    <= '0;
      sum_q    <= '0;
      vld_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      state_q  <= state_d;
      idx_q    <= idx_d;
      wd_q     <= wd_d;
      acc_q    <= acc_d;
      shadow_q <= shadow_d;
      vec_q    <= vec_d;
      sum_q    <= sum_d;
      vld_q    <= vld_d;
      err_q    <= err_d;
    end
  end

  assign backbone_vec        = vec_q;
  assign backbone_sum        = sum_q;
  assign backbone_vec_tvalid = vld_q;
  assign frame_err           = err_q;
  assign busy                = (state_q == S_COLLECT);

endmodule

// File: tb/tb_backbone_j_collect_fix.sv
// Directed bench for backbone_j_collect_fix with J=4, TIMEOUT=8; expected values hand-computed.
module tb_backbone_j_collect_fix;

  localparam int J       = 4;
  localparam int TIMEOUT = 8;
  localparam int SUM_W   = 32 + $clog2(J);

  logic               clk = 1'b0;
  logic               rst_n;
  logic [31:0]        backbone;
  logic               backbone_tvalid;
  logic [31:0]        backbone_J;
  logic               backbone_J_tvalid;
  logic [J*32-1:0]    backbone_vec;
  logic               backbone_vec_tvalid;
  logic [SUM_W-1:0]   backbone_sum;
  logic               busy;
  logic               frame_err;

  int checks   = 0;
  int failures = 0;
  int err_cnt  = 0;
  int vld_cnt  = 0;
  int err_base;
  int vld_base;

  backbone_j_collect_fix #(.J(J), .TIMEOUT(TIMEOUT)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .backbone            (backbone),
    .backbone_tvalid     (backbone_tvalid),
    .backbone_J          (backbone_J),
    .backbone_J_tvalid   (backbone_J_tvalid),
    .backbone_vec        (backbone_vec),
    .backbone_vec_tvalid (backbone_vec_tvalid),
    .backbone_sum        (backbone_sum),
    .busy                (busy),
    .frame_err           (frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (frame_err === 1'b1) err_cnt++;
      if (backbone_vec_tvalid === 1'b1) vld_cnt++;
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bb(input logic [31:0] v);
    backbone = v; backbone_tvalid = 1'b1;
    tick();
    backbone_tvalid = 1'b0;
  endtask

  task automatic send_j(input logic [31:0] v);
    backbone_J = v; backbone_J_tvalid = 1'b1;
    tick();
    backbone_J_tvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst_n = 1'b0;
    backbone = '0; backbone_tvalid = 1'b0;
    backbone_J = '0; backbone_J_tvalid = 1'b0;
    idle(3);
    check("rst_vec_held", backbone_vec, '0);
    check("rst_busy_held", busy, 1'b0);
    rst_n = 1'b1;
    tick();
    check("rst_vec", backbone_vec, '0);
    check("rst_sum", backbone_sum, '0);
    check("rst_vld", backbone_vec_tvalid, 1'b0);
    check("rst_err", frame_err, 1'b0);
    check("rst_busy", busy, 1'b0);

    // Nominal frame on consecutive cycles
    err_base = err_cnt; vld_base = vld_cnt;
    send_bb(32'd100);
    check("nom_busy", busy, 1'b1);
    send_j(32'd10);
    send_j(32'd20);
    send_j(32'd30);
    check("nom_vld_early", backbone_vec_tvalid, 1'b0);
    tick();
    check("nom_vld", backbone_vec_tvalid, 1'b1);
    check("nom_vec", backbone_vec, {32'd30, 32'd20, 32'd10, 32'd100});
    check("nom_sum", backbone_sum, 160);
    tick();
    check("nom_vld_drop", backbone_vec_tvalid, 1'b0);
    check("nom_busy_drop", busy, 1'b0);
    check("nom_err_count", err_cnt - err_base, 0);
    check("nom_vld_count", vld_cnt - vld_base, 1);

    // Gapped beats stay within the watchdog window
    err_base = err_cnt; vld_base = vld_cnt;
    send_bb(32'd100);
    idle(5);
    check("gap_busy1", busy, 1'b1);
    send_j(32'd10);
    idle(5);
    check("gap_busy2", busy, 1'b1);
    send_j(32'd20);
    idle(5);
    check("gap_busy3", busy, 1'b1);
    send_j(32'd30);
    tick();
    check("gap_vld", backbone_vec_tvalid, 1'b1);
    check("gap_vec", backbone_vec, {32'd30, 32'd20, 32'd10, 32'd100});
    check("gap_sum", backbone_sum, 160);
    check("gap_err_count", err_cnt - err_base, 0);
    tick();
    check("gap_vld_count", vld_cnt - vld_base, 1);

    // Restart mid-frame
    err_base = err_cnt;
    send_bb(32'd1);
    send_j(32'd2);
    send_bb(32'd7);
    check("rs_err", frame_err, 1'b1);
    send_j(32'd3);
    check("rs_err_clear", frame_err, 1'b0);
    send_j(32'd4);
    send_j(32'd5);
    tick();
    check("rs_vld", backbone_vec_tvalid, 1'b1);
    check("rs_vec", backbone_vec, {32'd5, 32'd4, 32'd3, 32'd7});
    check("rs_sum", backbone_sum, 19);
    check("rs_err_count", err_cnt - err_base, 1);
    tick();

    // Watchdog timeout then an orphan beat
    vld_base = vld_cnt;
    send_bb(32'd9);
    send_j(32'd1);
    idle(TIMEOUT - 1);
    check("to_busy_before", busy, 1'b1);
    check("to_err_before", frame_err, 1'b0);
    tick();
    check("to_err", frame_err, 1'b1);
    check("to_busy", busy, 1'b0);
    tick();
    check("to_err_clear", frame_err, 1'b0);
    check("to_vec_kept", backbone_vec, {32'd5, 32'd4, 32'd3, 32'd7});
    check("to_sum_kept", backbone_sum, 19);
    send_j(32'h55);
    check("orph_err", frame_err, 1'b1);
    check("orph_busy", busy, 1'b0);
    tick();
    check("orph_vld_count", vld_cnt - vld_base, 0);

    // Both strobes together in IDLE: frame starts, J beat dropped
    backbone = 32'd11; backbone_tvalid = 1'b1;
    backbone_J = 32'd99; backbone_J_tvalid = 1'b1;
    tick();
    backbone_tvalid = 1'b0; backbone_J_tvalid = 1'b0;
    check("both_err", frame_err, 1'b1);
    check("both_busy", busy, 1'b1);
    send_j(32'd1);
    send_j(32'd2);
    send_j(32'd3);
    tick();
    check("both_vec", backbone_vec, {32'd3, 32'd2, 32'd1, 32'd11});
    check("both_sum", backbone_sum, 17);

    // Back-to-back frames: new start lands in the DONE cycle
    err_base = err_cnt;
    send_bb(32'd1);
    send_j(32'd2);
    send_j(32'd3);
    send_j(32'd4);
    send_bb(32'd50);
    check("b2b_vld1", backbone_vec_tvalid, 1'b1);
    check("b2b_vec1", backbone_vec, {32'd4, 32'd3, 32'd2, 32'd1});
    check("b2b_sum1", backbone_sum, 10);
    check("b2b_busy", busy, 1'b1);
    send_j(32'd60);
    send_j(32'd70);
    send_j(32'd80);
    tick();
    check("b2b_vld2", backbone_vec_tvalid, 1'b1);
    check("b2b_vec2", backbone_vec, {32'd80, 32'd70, 32'd60, 32'd50});
    check("b2b_sum2", backbone_sum, 260);
    check("b2b_err_count", err_cnt - err_base, 0);

    // Asynchronous reset in the middle of a frame
    send_bb(32'd5);
    send_j(32'd6);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_vec", backbone_vec, '0);
    check("arst_sum", backbone_sum, '0);
    check("arst_busy", busy, 1'b0);
    check("arst_err", frame_err, 1'b0);
    tick();
    rst_n = 1'b1;
    err_base = err_cnt;
    idle(2);
    check("arst_err_after", err_cnt - err_base, 0);
    check("arst_busy_after", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/backbone_j_collect_fix.md
# backbone_J_collect_fix

Receive-side companion of the per-index backbone generator. It accepts the raw backbone word at frame start, then the J-1 streamed backbone_J quotients for indices 1..J-1. It assembles them into one parallel J-entry vector, with entry 0 holding the raw backbone, and computes the frame sum. It sits between the backbone_J generator and downstream normalisation/sampling logic that needs all J values at once. The output vector is double-buffered, so it holds steady until the next complete frame.

## Interface
Parameters:
- J, 14, number of entries per frame; legal range J ≥ 2
- TIMEOUT, 64, maximum idle cycles allowed between accepted beats inside a frame before it is aborted; legal range TIMEOUT ≥ 1
- SUM_W (localparam), 32+$clog2(J), width of the sum output
- J_WIDTH (localparam), $clog2(J)+1, width of the index counter

Ports:
- clk  in  1  single clock, all logic on the rising edge
- rst_n  in  1  asynchronous active-low reset
- backbone  in  32  raw backbone word; becomes entry 0
- backbone_tvalid  in  1  frame-start strobe; samples backbone
- backbone_J  in  32  quotient for the current index
- backbone_J_tvalid  in  1  one beat per index, 1..J-1 in order
- backbone_vec  out  J*32  completed frame; entry k is at [k*32 +: 32]
- backbone_vec_tvalid  out  1  one-cycle pulse when backbone_vec/backbone_sum update
- backbone_sum  out  SUM_W  unsigned sum of all J entries of the completed frame
- busy  out  1  high while a frame is being collected
- frame_err  out  1  one-cycle pulse on any protocol violation

## Operation
- State machine has three states: IDLE, COLLECT, DONE.
- IDLE:
  - backbone_tvalid: write backbone to shadow entry 0, set acc = backbone, set idx = 1, clear watchdog, go to COLLECT.
  - backbone_J_tvalid without backbone_tvalid: orphan beat. Drop it and pulse frame_err.
  - Both asserted in the same cycle: start the frame, drop the J beat, pulse frame_err.
- COLLECT:
  - backbone_J_tvalid: write shadow[idx] = backbone_J, acc += backbone_J, clear watchdog.
    - If idx == J-1, go to DONE.
    - Otherwise idx = idx+1.
  - backbone_tvalid: restart. Shadow entry 0 = backbone, acc = backbone, idx = 1, pulse frame_err. Restart takes priority over a simultaneous J beat, which is dropped.
  - No beat: watchdog += 1. When the watchdog reaches TIMEOUT, go to IDLE and pulse frame_err; shadow contents are discarded.
- DONE (one cycle):
  - Copy shadow to backbone_vec and acc to backbone_sum, pulse backbone_vec_tvalid, go to IDLE.
  - backbone_tvalid in DONE is handled as in IDLE. Back-to-back frames are legal: the shadow is reloaded in the same cycle the copy happens, and the copy reads the pre-update shadow.
  - backbone_J_tvalid in DONE is an orphan: dropped, frame_err pulses.
- Arithmetic: acc is unsigned, SUM_W bits wide, and cannot overflow for J entries of 32 bits.
- backbone_vec and backbone_sum change only in DONE. Aborted or restarted frames never disturb them.
- busy = (state == COLLECT).

## Timing
- Reset (asynchronous, rst_n low) sets:
  - state = IDLE, idx = 0, watchdog = 0, acc = 0, shadow = 0
  - backbone_vec = 0, backbone_sum = 0
  - backbone_vec_tvalid = 0, busy = 0, frame_err = 0
- Reset mid-frame discards the partial frame with no error pulse.
- Latency: the last beat (index J-1) is accepted at edge t. backbone_vec_tvalid is high during cycle t+1 to t+2, with data valid in the same cycle.
- The minimum frame length is J cycles from backbone_tvalid to the final beat; beats on consecutive cycles are accepted.
- No backpressure: the block always accepts input and never stalls the generator.
- frame_err is registered. It is high for exactly one cycle, the cycle after the offending edge.
- Timeout: after TIMEOUT consecutive beat-less cycles in COLLECT, state is IDLE at the following edge, with frame_err high that cycle.

## Test plan
- J=4, reset state: hold rst_n low, then release. backbone_vec=0, backbone_sum=0, all strobes 0, busy=0.
- Nominal frame (J=4): backbone=100, then J beats 10, 20, 30 on consecutive cycles. One pulse with vec={30,20,10,100} (MSB→LSB), sum=160, pulse one cycle after the 30 beat, frame_err never high.
- Gapped beats within TIMEOUT=8: same data with 5-cycle gaps. Same result, busy high throughout.
- Restart mid-frame: backbone=1, beat 2, then backbone=7, beats 3, 4, 5. One frame_err pulse after the second backbone_tvalid. Output vec={5,4,3,7}, sum=19.
- Timeout and orphan: backbone=9, beat 1, then 8 idle cycles (TIMEOUT=8). frame_err pulses, busy drops, and backbone_vec keeps the previous frame. A later lone backbone_J_tvalid gives another frame_err with no output pulse.
- Back-to-back frames plus async reset: a second backbone_tvalid arrives in the DONE cycle. Both frames are output correctly. Asserting rst_n mid-frame clears all outputs immediately with no frame_err.
